renkon_img_reader: RTL and testbench

RENKON_IMG_READER -- requirements
Module: renkon_img_reader

---
 rtl/renkon_img_reader.sv | 150 +++++++++++++++
 tb/tb_renkon_img_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renkon_img_reader.sv
// rtl/renkon_img_reader.sv - burst reader streaming image memory words out with backpressure
//
// Reads `count` words starting at `base_addr` from a synchronous image memory
// and streams them through a 2-entry FIFO with a valid/ready handshake.
//
// Optional feature macro: RENKON_IMG_READER_STRIDE_EN
//   defined   -> adds input `stride`, the address increment per word
//   undefined -> the address increments by 1 per word
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   start              begins a burst (sampled only while idle)
//   base_addr, count   burst start address and word count, captured on start
//   stride             (macro only) address increment per word
//   mem_addr           read address to the image memory
//   mem_rdata          read data, valid the cycle after mem_addr is presented
//   out_data/out_valid/out_ready   output stream
//   busy, done         burst in progress / one-cycle completion pulse
module renkon_img_reader #(
  parameter int DWIDTH  = 16,
  parameter int IMGSIZE = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IMGSIZE-1:0]        base_addr,
  input  logic [IMGSIZE:0]          count,
`ifdef RENKON_IMG_READER_STRIDE_EN
  input  logic [IMGSIZE-1:0]        stride,
`endif
  output logic [IMGSIZE-1:0]        mem_addr,
  input  logic signed [DWIDTH-1:0]  mem_rdata,
  output logic signed [DWIDTH-1:0]  out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t                    state_q, state_d;
  logic [IMGSIZE-1:0]        next_addr_q;   // address of the next read to issue
  logic [IMGSIZE-1:0]        last_addr_q;   // most recently issued address
  logic [IMGSIZE-1:0]        step;
  logic [IMGSIZE:0]          issue_left_q;
  logic [IMGSIZE:0]          xfer_left_q;
  logic                      inflight_q;    // mem_rdata carries a requested word this cycle
  logic signed [DWIDTH-1:0]  fifo_q [2];
  logic                      rd_ptr_q, wr_ptr_q;
  logic [1:0]                occ_q;
  logic [2:0]                pending;
  logic                      xfer, issue, accept;

  assign xfer = out_valid && out_ready;

  // Words that will sit in the FIFO after this edge; a new read may only be
  // issued if its data will still find a free slot when it returns.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (count == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        if (issue_left_q != '0 && pending < 3'd2) begin
          issue = 1'b1;
          if (issue_left_q == (IMGSIZE+1)'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && xfer_left_q == (IMGSIZE+1)'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RENKON_IMG_READER_STRIDE_EN
  logic [IMGSIZE-1:0] step_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= '0;
    end else if (accept) begin
      step_q <= stride;
    end
  end

  assign step = step_q;
`else
  assign step = {{(IMGSIZE-1){1'b0}}, 1'b1};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      next_addr_q  <= '0;
      last_addr_q  <= '0;
      issue_left_q <= '0;
      xfer_left_q  <= '0;
      inflight_q   <= 1'b0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      occ_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        next_addr_q  <= base_addr;
        issue_left_q <= count;
        xfer_left_q  <= count;
      end
      if (issue) begin
        last_addr_q  <= next_addr_q;
        next_addr_q  <= next_addr_q + step;  // wraps modulo memory size
        issue_left_q <= issue_left_q - 1'b1;
      end
      if (xfer) begin
        xfer_left_q <= xfer_left_q - 1'b1;
        rd_ptr_q    <= ~rd_ptr_q;
      end
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, xfer};
    end
  end

  // The address is presented in the same cycle the read is decided so the
  // word returns on the following cycle; otherwise the last address is held.
  assign mem_addr  = issue ? next_addr_q : last_addr_q;
  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = (occ_q != '0);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_renkon_img_reader.sv
// tb/tb_renkon_img_reader.sv - self-checking bench for renkon_img_reader
module tb_renkon_img_reader;

  logic               clk;
  logic               rst;
  logic               start;
  logic [11:0]        base_addr;
  logic [12:0]        count;
  logic [11:0]        stride;
  logic [11:0]        mem_addr;
  logic signed [15:0] mem_rdata;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;

  int vectors;
  int miscompares;
  int xfer_cnt;
  int ready_mode;
  int pat;
  logic [11:0] tb_stride;

  logic signed [15:0] mem [4096];
  logic signed [15:0] exp_q [$];

  logic               stall_prev;
  logic signed [15:0] stall_data;

  renkon_img_reader #(.DWIDTH(16), .IMGSIZE(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
`ifdef RENKON_IMG_READER_STRIDE_EN
    .stride    (stride),
`endif
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image memory: one-cycle read latency.
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  // Downstream ready: always 1, or the repeating pattern 1,0,0.
  always @(posedge clk) begin
    #1;
    if (ready_mode != 0) begin
      out_ready = (pat % 3 == 0);
      pat++;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Scoreboard monitor: transfers popped and compared; stalled data must hold.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        vectors++;
        if (!out_valid || out_data !== stall_data) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", out_valid, out_data, stall_data);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word: got %h, required no transfer", out_data);
        end else begin
          logic signed [15:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            miscompares++;
            $display("FAIL stream_data: got %h required %h", out_data, e);
          end
        end
        xfer_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Caller must be just after a rising edge; start is accepted at the next edge.
  // k counts falling edges after the accepting edge.
  task automatic run_burst(input logic [11:0] b, input logic [12:0] c, input bit restart,
                           output int fv, output int da, output int dp, output int bc, output int nx);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < int'(c); i++) begin
      exp_q.push_back(mem[a]);
      a = a + tb_stride;
    end
    xfer_cnt  = 0;
    start     = 1'b1;
    base_addr = b;
    count     = c;
    stride    = tb_stride;
    @(posedge clk);
    #1 start = 1'b0;
    base_addr = '0;
    count     = '0;
    fv = -1; da = -1; dp = 0; bc = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (restart && k == 1) begin
        start = 1'b1; base_addr = 12'h300; count = 13'd5;
      end
      if (restart && k == 2) start = 1'b0;
      if (out_valid && fv < 0) fv = k;
      if (busy) bc++;
      if (done) begin
        dp++;
        if (da < 0) da = k;
      end
      if (da >= 0 && k >= da + 2) break;
    end
    nx = xfer_cnt;
    vectors++;
    if (da < 0) begin
      miscompares++;
      $display("FAIL burst_timeout: done never seen for base=%h count=%0d", b, c);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL words_missing: %0d left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; stride = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, out_valid} !== 3'b000 || out_data !== 16'sd0 || mem_addr !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b valid=%b data=%h addr=%h required all 0",
               busy, done, out_valid, out_data, mem_addr);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    run_burst(12'h010, 13'd4, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (fv != 2) begin miscompares++; $display("FAIL basic_first_valid: %0d required 2", fv); end
    vectors++;
    if (da != 6) begin miscompares++; $display("FAIL basic_done_cycle: %0d required 6", da); end
    vectors++;
    if (dp != 1 || nx != 4) begin
      miscompares++; $display("FAIL basic_counts: done_pulses=%0d xfers=%0d required 1 and 4", dp, nx);
    end
    vectors++;
    if (bc != 7) begin miscompares++; $display("FAIL basic_busy_cycles: %0d required 7", bc); end
  endtask

  task automatic test_wrap;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    run_burst(12'hFFE, 13'd4, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (nx != 4 || dp != 1) begin
      miscompares++; $display("FAIL wrap_counts: xfers=%0d done_pulses=%0d required 4 and 1", nx, dp);
    end
    vectors++;
    if (mem_addr !== 12'h001) begin
      miscompares++; $display("FAIL wrap_addr_hold: %h required 001", mem_addr);
    end
  endtask

  task automatic test_ignore_start;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    run_burst(12'h040, 13'd3, 1'b1, fv, da, dp, bc, nx);
    vectors++;
    if (nx != 3 || dp != 1 || da != 5) begin
      miscompares++;
      $display("FAIL ignore_start: xfers=%0d done_pulses=%0d done_at=%0d required 3,1,5", nx, dp, da);
    end
  endtask

  task automatic test_stall;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    pat = 0;
    ready_mode = 1;
    run_burst(12'h080, 13'd8, 1'b0, fv, da, dp, bc, nx);
    ready_mode = 0;
    vectors++;
    if (nx != 8 || dp != 1) begin
      miscompares++; $display("FAIL stall_counts: xfers=%0d done_pulses=%0d required 8 and 1", nx, dp);
    end
  endtask

  task automatic test_zero_count;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    run_burst(12'h123, 13'd0, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (fv != -1 || nx != 0) begin
      miscompares++; $display("FAIL zero_no_valid: first_valid=%0d xfers=%0d required none", fv, nx);
    end
    vectors++;
    if (bc != 1 || da != 0 || dp != 1) begin
      miscompares++;
      $display("FAIL zero_timing: busy=%0d done_at=%0d pulses=%0d required 1,0,1", bc, da, dp);
    end
  endtask

  task automatic test_full_memory;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    run_burst(12'h123, 13'd4096, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (nx != 4096 || da != 4098 || dp != 1) begin
      miscompares++;
      $display("FAIL full_memory: xfers=%0d done_at=%0d pulses=%0d required 4096,4098,1", nx, da, dp);
    end
  endtask

  task automatic test_reset_mid_burst;
    int fv, da, dp, bc, nx;
    int guard;
    logic [11:0] a;
    @(posedge clk); #1;
    a = 12'h200;
    for (int i = 0; i < 10; i++) begin exp_q.push_back(mem[a]); a = a + tb_stride; end
    xfer_cnt = 0;
    start = 1'b1; base_addr = 12'h200; count = 13'd10; stride = tb_stride;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (xfer_cnt < 3 && guard < 100) begin @(negedge clk); guard++; end
    vectors++;
    if (xfer_cnt < 3) begin
      miscompares++; $display("FAIL abort_progress: xfers=%0d required 3", xfer_cnt);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, done, out_valid} !== 3'b000 || out_data !== 16'sd0 || mem_addr !== 12'h000) begin
      miscompares++;
      $display("FAIL abort_reset_state: busy=%b done=%b valid=%b data=%h addr=%h required all 0",
               busy, done, out_valid, out_data, mem_addr);
    end
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: %b required 0", done); end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    run_burst(12'h050, 13'd2, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (fv != 2 || da != 4 || dp != 1 || nx != 2) begin
      miscompares++;
      $display("FAIL post_reset_burst: fv=%0d done_at=%0d pulses=%0d xfers=%0d required 2,4,1,2", fv, da, dp, nx);
    end
  endtask

`ifdef RENKON_IMG_READER_STRIDE_EN
  task automatic test_stride;
    int fv, da, dp, bc, nx;
    @(posedge clk); #1;
    tb_stride = 12'h020;
    run_burst(12'h100, 13'd3, 1'b0, fv, da, dp, bc, nx);
    vectors++;
    if (nx != 3 || mem_addr !== 12'h140) begin
      miscompares++; $display("FAIL stride: xfers=%0d last_addr=%h required 3 and 140", nx, mem_addr);
    end
    tb_stride = 12'h001;
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0; xfer_cnt = 0; ready_mode = 0; pat = 0;
    tb_stride = 12'h001;
    out_ready = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_ignore_start();
    test_stall();
    test_zero_count();
    test_full_memory();
    test_reset_mid_burst();
`ifdef RENKON_IMG_READER_STRIDE_EN
    test_stride();
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
